// File: rtl/bless_pkg.sv
// Shared constants for the BLESS deflection router: port indices and flit field positions.
package bless_pkg;

  localparam int PORT_W        = 0;
  localparam int PORT_E        = 1;
  localparam int PORT_S        = 2;
  localparam int PORT_N        = 3;
  localparam int NUM_NET_PORTS = 4;

  // One bit per mesh port, indexed by the PORT_* constants.
  localparam int PROD_W = NUM_NET_PORTS;

  localparam int DST_Y_LO = 0;

  function automatic int ageLo(input int flitW, input int ageW);
    return flitW - ageW;
  endfunction

  function automatic int dstXLo(input int coordW);
    return coordW;
  endfunction

endpackage

// File: rtl/bless_port_alloc.sv
// Combinational oldest-first ordering, ejection pick and sequential port allocation; zero latency.
// Never stalls network flits; injection room reported via injRoom; BLESS_ROUTER_STATS_EN adds deflectNum.
module bless_port_alloc
  import bless_pkg::*;
#(
  parameter int FLIT_W    = 64,
  parameter int COORD_W   = 3,
  parameter int AGE_W     = 8,
  parameter int NUM_EJECT = 1,
  parameter int CUR_X     = 0,
  parameter int CUR_Y     = 0
) (
  input  logic [NUM_NET_PORTS*FLIT_W-1:0] netFlit,
  input  logic [NUM_NET_PORTS-1:0]        netVld,
  input  logic [FLIT_W-1:0]               injFlit,
  input  logic                            injTake,
  output logic                            injRoom,
  output logic [NUM_NET_PORTS*FLIT_W-1:0] outFlit,
  output logic [NUM_NET_PORTS-1:0]        outVld,
  output logic [NUM_EJECT*FLIT_W-1:0]     ejFlit,
  output logic [NUM_EJECT-1:0]            ejVld
`ifdef BLESS_ROUTER_STATS_EN
  ,
  output logic [2:0]                      deflectNum
`endif
);

  localparam int AGE_LO = ageLo(FLIT_W, AGE_W);
  localparam int X_LO   = dstXLo(COORD_W);
  localparam logic [COORD_W-1:0] CUR_XC = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CUR_YC = COORD_W'(CUR_Y);

  function automatic logic [PROD_W-1:0] prodOf(input logic [COORD_W-1:0] dx,
                                                input logic [COORD_W-1:0] dy);
    logic [PROD_W-1:0] p;
    p         = '0;
    p[PORT_W] = dx < CUR_XC;
    p[PORT_E] = dx > CUR_XC;
    p[PORT_S] = dy < CUR_YC;
    p[PORT_N] = dy > CUR_YC;
    return p;
  endfunction

  function automatic logic [PROD_W-1:0] lowestOne(input logic [PROD_W-1:0] v);
    return v & (~v + PROD_W'(1));
  endfunction

  logic [AGE_W-1:0]  age   [NUM_NET_PORTS];
  logic [PROD_W-1:0] prod  [NUM_NET_PORTS];
  logic [1:0]        rank  [NUM_NET_PORTS];
  logic [1:0]        order [NUM_NET_PORTS];

  always_comb begin
    for (int i = 0; i < NUM_NET_PORTS; i++) begin
      age[i]  = netFlit[i*FLIT_W + AGE_LO +: AGE_W];
      prod[i] = prodOf(netFlit[i*FLIT_W + X_LO +: COORD_W],
                       netFlit[i*FLIT_W + DST_Y_LO +: COORD_W]);
    end
  end

  // Rank = number of flits that beat this one (older, or same age on a lower port).
  always_comb begin
    for (int i = 0; i < NUM_NET_PORTS; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NUM_NET_PORTS; j++) begin
        if (j != i && (age[j] > age[i] || (age[j] == age[i] && j < i)))
          rank[i] = rank[i] + 2'd1;
      end
    end
    for (int i = 0; i < NUM_NET_PORTS; i++) order[i] = '0;
    for (int i = 0; i < NUM_NET_PORTS; i++) order[rank[i]] = 2'(i);
  end

  // Kept apart from the allocator so inj_rdy does not depend on the injection decision.
  logic [2:0] nVld, nLoc, nEj;
  always_comb begin
    nVld = '0;
    nLoc = '0;
    for (int i = 0; i < NUM_NET_PORTS; i++) begin
      nVld = nVld + 3'(netVld[i]);
      if (netVld[i] && prod[i] == '0) nLoc = nLoc + 3'd1;
    end
    nEj     = (nLoc > 3'(NUM_EJECT)) ? 3'(NUM_EJECT) : nLoc;
    injRoom = (nVld - nEj) < 3'd4;
  end

  logic [PROD_W-1:0] free, grant, curProd, injProd;
  logic [FLIT_W-1:0] curF, injF;
  logic [1:0]        idx, ejCnt;

  always_comb begin
    free    = '1;
    outFlit = '0;
    outVld  = '0;
    ejFlit  = '0;
    ejVld   = '0;
    ejCnt   = '0;
    grant   = '0;
    idx     = '0;
    curF    = '0;
    curProd = '0;
`ifdef BLESS_ROUTER_STATS_EN
    deflectNum = '0;
`endif
    injF    = injFlit;
    injF[AGE_LO +: AGE_W] = '0;
    injProd = prodOf(injFlit[X_LO +: COORD_W], injFlit[DST_Y_LO +: COORD_W]);

    for (int p = 0; p < NUM_NET_PORTS; p++) begin
      idx     = order[p];
      curF    = netFlit[idx*FLIT_W +: FLIT_W];
      curProd = prod[idx];
      grant   = '0;
      if (netVld[idx]) begin
        if (curProd == '0 && ejCnt < 2'(NUM_EJECT)) begin
          for (int k = 0; k < NUM_EJECT; k++) begin
            if (ejCnt == 2'(k)) begin
              ejFlit[k*FLIT_W +: FLIT_W] = curF;
              ejVld[k]                   = 1'b1;
            end
          end
          ejCnt = ejCnt + 2'd1;
        end else begin
          // Port index order already puts the X direction ahead of Y.
          grant = lowestOne(curProd & free);
          if (grant == '0) begin
            grant = lowestOne(free);
`ifdef BLESS_ROUTER_STATS_EN
            deflectNum = deflectNum + 3'd1;
`endif
          end
        end
      end
      for (int q = 0; q < NUM_NET_PORTS; q++)
        if (grant[q]) outFlit[q*FLIT_W +: FLIT_W] = curF;
      outVld = outVld | grant;
      free   = free & ~grant;
    end

    // Injection goes last; a local-destined injected flit is routed, never ejected.
    grant = '0;
    if (injTake) begin
      grant = lowestOne(injProd & free);
      if (grant == '0) begin
        grant = lowestOne(free);
`ifdef BLESS_ROUTER_STATS_EN
        deflectNum = deflectNum + 3'd1;
`endif
      end
    end
    for (int q = 0; q < NUM_NET_PORTS; q++)
      if (grant[q]) outFlit[q*FLIT_W +: FLIT_W] = injF;
    outVld = outVld | grant;
  end

endmodule

// File: rtl/bless_router_param.sv
// Bufferless deflection router node: din->dout/ej 2 cycles, inj->dout 1 cycle; network never backpressured,
// injection held off via inj_rdy when all ports are taken. BLESS_ROUTER_STATS_EN adds deflect_cnt/eject_cnt.
module bless_router_param
  import bless_pkg::*;
#(
  parameter int FLIT_W    = 64,
  parameter int COORD_W   = 3,
  parameter int AGE_W     = 8,
  parameter int NUM_EJECT = 1,
  parameter int CUR_X     = 0,
  parameter int CUR_Y     = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_NET_PORTS*FLIT_W-1:0] din_net,
  input  logic [NUM_NET_PORTS-1:0]        din_vld,
  output logic [NUM_NET_PORTS*FLIT_W-1:0] dout_net,
  output logic [NUM_NET_PORTS-1:0]        dout_vld,
  input  logic [FLIT_W-1:0]               inj_flit,
  input  logic                            inj_vld,
  output logic                            inj_rdy,
  output logic [NUM_EJECT*FLIT_W-1:0]     ej_flit,
  output logic [NUM_EJECT-1:0]            ej_vld
`ifdef BLESS_ROUTER_STATS_EN
  ,
  output logic [31:0]                     deflect_cnt,
  output logic [31:0]                     eject_cnt
`endif
);

  localparam int AGE_LO = ageLo(FLIT_W, AGE_W);

  logic [NUM_NET_PORTS*FLIT_W-1:0] s0Flit, s0Nxt, allocFlit;
  logic [NUM_NET_PORTS-1:0]        s0Vld, allocVld;
  logic [NUM_EJECT*FLIT_W-1:0]     allocEjFlit;
  logic [NUM_EJECT-1:0]            allocEjVld;
  logic [FLIT_W-1:0]               ageF;
  logic                            injRoom, injTake;

  // Age bumps on entry so the allocator sees this hop counted; invalid slots stay zero.
  always_comb begin
    s0Nxt = '0;
    ageF  = '0;
    for (int i = 0; i < NUM_NET_PORTS; i++) begin
      if (din_vld[i]) begin
        ageF = din_net[i*FLIT_W +: FLIT_W];
        if (ageF[AGE_LO +: AGE_W] != '1)
          ageF[AGE_LO +: AGE_W] = ageF[AGE_LO +: AGE_W] + AGE_W'(1);
        s0Nxt[i*FLIT_W +: FLIT_W] = ageF;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0Flit <= '0;
      s0Vld  <= '0;
    end else begin
      s0Flit <= s0Nxt;
      s0Vld  <= din_vld;
    end
  end

  assign inj_rdy = reset && injRoom;
  assign injTake = inj_vld && inj_rdy;

`ifdef BLESS_ROUTER_STATS_EN
  logic [2:0] deflectNum;
`endif

  bless_port_alloc #(
    .FLIT_W   (FLIT_W),
    .COORD_W  (COORD_W),
    .AGE_W    (AGE_W),
    .NUM_EJECT(NUM_EJECT),
    .CUR_X    (CUR_X),
    .CUR_Y    (CUR_Y)
  ) uAlloc (
    .netFlit   (s0Flit),
    .netVld    (s0Vld),
    .injFlit   (inj_flit),
    .injTake   (injTake),
    .injRoom   (injRoom),
    .outFlit   (allocFlit),
    .outVld    (allocVld),
    .ejFlit    (allocEjFlit),
    .ejVld     (allocEjVld)
`ifdef BLESS_ROUTER_STATS_EN
    ,
    .deflectNum(deflectNum)
`endif
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_net <= '0;
      dout_vld <= '0;
      ej_flit  <= '0;
      ej_vld   <= '0;
    end else begin
      dout_net <= allocFlit;
      dout_vld <= allocVld;
      ej_flit  <= allocEjFlit;
      ej_vld   <= allocEjVld;
    end
  end

`ifdef BLESS_ROUTER_STATS_EN
  logic [1:0]  ejPop;
  logic [32:0] defSum, ejSum;

  always_comb begin
    ejPop = '0;
    for (int k = 0; k < NUM_EJECT; k++) ejPop = ejPop + 2'(ej_vld[k]);
    defSum = {1'b0, deflect_cnt} + 33'(deflectNum);
    ejSum  = {1'b0, eject_cnt} + 33'(ejPop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deflect_cnt <= '0;
      eject_cnt   <= '0;
    end else begin
      deflect_cnt <= defSum[32] ? '1 : defSum[31:0];
      eject_cnt   <= ejSum[32] ? '1 : ejSum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_bless_router_param.sv
// Scoreboard bench for bless_router_param at node (2,2) with a single ejection slot.
module tb_bless_router_param;

  localparam int FW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*FW-1:0] din_net, dout_net;
  logic [3:0]    din_vld, dout_vld;
  logic [FW-1:0] inj_flit, ej_flit;
  logic          inj_vld, inj_rdy;
  logic [0:0]    ej_vld;
`ifdef BLESS_ROUTER_STATS_EN
  logic [31:0]   deflect_cnt, eject_cnt;
`endif

  always #5 clk = ~clk;

  bless_router_param #(
    .FLIT_W(FW), .COORD_W(3), .AGE_W(8), .NUM_EJECT(1), .CUR_X(2), .CUR_Y(2)
  ) dut (
    .clk(clk), .reset(reset),
    .din_net(din_net), .din_vld(din_vld),
    .dout_net(dout_net), .dout_vld(dout_vld),
    .inj_flit(inj_flit), .inj_vld(inj_vld), .inj_rdy(inj_rdy),
    .ej_flit(ej_flit), .ej_vld(ej_vld)
`ifdef BLESS_ROUTER_STATS_EN
    , .deflect_cnt(deflect_cnt), .eject_cnt(eject_cnt)
`endif
  );

  typedef struct {
    int              due;
    logic [4*FW-1:0] net;
    logic [3:0]      vld;
    logic [FW-1:0]   ej;
    logic            ejv;
  } expT;

  expT sb[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int age, input int dx, input int dy, input int tag);
    logic [FW-1:0] f;
    f        = '0;
    f[63:56] = age[7:0];
    f[15:8]  = tag[7:0];
    f[5:3]   = dx[2:0];
    f[2:0]   = dy[2:0];
    return f;
  endfunction

  function automatic logic [4*FW-1:0] pack(input logic [FW-1:0] w, input logic [FW-1:0] e,
                                           input logic [FW-1:0] s, input logic [FW-1:0] n);
    return {n, s, e, w};
  endfunction

  task automatic pushExp(input int due, input logic [4*FW-1:0] net, input logic [3:0] vld,
                         input logic [FW-1:0] ej, input logic ejv);
    expT e;
    e.due = due; e.net = net; e.vld = vld; e.ej = ej; e.ejv = ejv;
    sb.push_back(e);
  endtask

  // One cycle of network input, expectation due two cycles later.
  task automatic netTest(input logic [4*FW-1:0] net, input logic [3:0] vld,
                         input logic [4*FW-1:0] expNet, input logic [3:0] expVld,
                         input logic [FW-1:0] expEj, input logic expEjv);
    @(negedge clk);
    din_net = net;
    din_vld = vld;
    pushExp(cyc + 2, expNet, expVld, expEj, expEjv);
    @(negedge clk);
    din_net = '0;
    din_vld = '0;
  endtask

  always @(negedge clk) begin
    expT e;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkEq("due_cycle", cyc, e.due);
      checkEq("dout_vld", dout_vld, e.vld);
      checkEq("dout_net", dout_net, e.net);
      checkEq("ej_vld", ej_vld, e.ejv);
      checkEq("ej_flit", ej_flit, e.ej);
    end else begin
      checkEq("idle_vld", {ej_vld, dout_vld}, 5'b0);
      checkEq("idle_dat", |{ej_flit, dout_net}, 1'b0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; din_net = '0; din_vld = '0; inj_flit = '0; inj_vld = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkEq("rst_dout_vld", dout_vld, 4'b0);
    checkEq("rst_dout_net", dout_net, 256'b0);
    checkEq("rst_ej_vld", ej_vld, 1'b0);
    checkEq("rst_inj_rdy", inj_rdy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1 checkEq("inj_rdy_idle", inj_rdy, 1'b1);

    // Single productive hop east.
    netTest(pack(mk(5,4,2,'h01), '0, '0, '0), 4'b0001,
            pack('0, mk(6,4,2,'h01), '0, '0), 4'b0010, '0, 1'b0);
    // Older N wins E; W deflected to W.
    netTest(pack(mk(3,4,2,'h21), '0, '0, mk(9,4,2,'h22)), 4'b1001,
            pack(mk(4,4,2,'h21), mk(10,4,2,'h22), '0, '0), 4'b0011, '0, 1'b0);
    // Two local flits, one slot: older ejects, other deflected to lowest free.
    netTest(pack('0, mk(7,2,2,'h41), mk(2,2,2,'h42), '0), 4'b0110,
            pack(mk(3,2,2,'h42), '0, '0, '0), 4'b0001, mk(8,2,2,'h41), 1'b1);
    // Three local flits of equal age: lowest index ejects.
    netTest(pack(mk(5,2,2,'h61), mk(5,2,2,'h62), '0, mk(5,2,2,'h63)), 4'b1011,
            pack(mk(6,2,2,'h62), mk(6,2,2,'h63), '0, '0), 4'b0011, mk(6,2,2,'h61), 1'b1);
    // Age saturation, equal saturated ages resolved by port index.
    netTest(pack(mk(255,4,2,'h51), '0, '0, mk(254,2,0,'h52)), 4'b1001,
            pack('0, mk(255,4,2,'h51), mk(255,2,0,'h52), '0), 4'b0110, '0, 1'b0);

    // Injection with N free.
    @(negedge clk);
    din_net = pack(mk(1,4,2,'h31), mk(1,0,2,'h32), mk(1,2,0,'h33), '0);
    din_vld = 4'b0111;
    pushExp(cyc + 2, pack(mk(2,0,2,'h32), mk(2,4,2,'h31), mk(2,2,0,'h33), mk(0,2,3,'h34)),
            4'b1111, '0, 1'b0);
    @(negedge clk);
    din_net = '0; din_vld = '0;
    inj_vld = 1'b1; inj_flit = mk('h77,2,3,'h34);
    #1 checkEq("inj_rdy_three", inj_rdy, 1'b1);
    @(negedge clk);
    inj_vld = 1'b0;

    // Four valid with one ejecting leaves room; injection deflected to the only free port.
    @(negedge clk);
    din_net = pack(mk(1,2,2,'h71), mk(1,0,2,'h72), mk(1,2,0,'h73), mk(1,2,4,'h74));
    din_vld = 4'b1111;
    pushExp(cyc + 2, pack(mk(2,0,2,'h72), mk(0,2,3,'h75), mk(2,2,0,'h73), mk(2,2,4,'h74)),
            4'b1111, mk(2,2,2,'h71), 1'b1);
    @(negedge clk);
    din_net = '0; din_vld = '0;
    inj_vld = 1'b1; inj_flit = mk('h33,2,3,'h75);
    #1 checkEq("inj_rdy_eject", inj_rdy, 1'b1);
    @(negedge clk);
    inj_vld = 1'b0;

    // Local-destined injection is routed, never ejected.
    @(negedge clk);
    inj_vld = 1'b1; inj_flit = mk('h20,2,2,'h55);
    pushExp(cyc + 1, pack(mk(0,2,2,'h55), '0, '0, '0), 4'b0001, '0, 1'b0);
    #1 checkEq("inj_rdy_empty", inj_rdy, 1'b1);
    @(negedge clk);
    inj_vld = 1'b0;

    // Four non-local flits block injection, then reset lands mid-traffic.
    @(negedge clk);
    din_net = pack(mk(1,4,2,'h11), mk(1,0,2,'h12), mk(1,2,4,'h13), mk(1,2,0,'h14));
    din_vld = 4'b1111;
    pushExp(cyc + 2, pack(mk(2,0,2,'h12), mk(2,4,2,'h11), mk(2,2,0,'h14), mk(2,2,4,'h13)),
            4'b1111, '0, 1'b0);
    @(negedge clk);
    din_net = pack(mk(1,4,2,'h81), mk(1,0,2,'h82), mk(1,2,4,'h83), mk(1,2,0,'h84));
    inj_vld = 1'b1; inj_flit = mk(0,2,3,'h99);
    #1 checkEq("inj_rdy_full", inj_rdy, 1'b0);
    @(negedge clk);
    din_net = '0; din_vld = '0; inj_vld = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkEq("midrst_dout_vld", dout_vld, 4'b0);
    checkEq("midrst_dout_net", dout_net, 256'b0);
    checkEq("midrst_ej_vld", ej_vld, 1'b0);
    checkEq("midrst_inj_rdy", inj_rdy, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkEq("postrst_inj_rdy", inj_rdy, 1'b1);

    repeat (8) @(negedge clk);
    checkEq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bless_router_param.md
Name: bless_router_param

Overview:
- Parametrised successor to the baseline BLESS bufferless deflection router: 4 mesh ports (W,E,S,N), local injection with ready/valid handshake, and 1..2 ejection slots.
- Adds explicit valid bits, configurable flit/coordinate/age widths, oldest-first arbitration with saturating age, and minimal-adaptive productive routing.
- Instantiated once per mesh node.

Parameters:
- FLIT_W, 64, flit width including header fields; excludes the valid bit.
- COORD_W, 3, width of each of dst_x and dst_y.
- AGE_W, 8, width of the age field.
- NUM_EJECT, 1, number of ejection slots per cycle; legal values 1 or 2.
- CUR_X, 0, X coordinate of this node.
- CUR_Y, 0, Y coordinate of this node.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- din_net  in  4*FLIT_W  network input flits; slot index 0=W, 1=E, 2=S, 3=N.
- din_vld  in  4  per-port input valid.
- dout_net  out  4*FLIT_W  network output flits; same slot order.
- dout_vld  out  4  per-port output valid.
- inj_flit  in  FLIT_W  local injection flit.
- inj_vld  in  1  injection request.
- inj_rdy  out  1  injection accepted this cycle when inj_vld && inj_rdy.
- ej_flit  out  NUM_EJECT*FLIT_W  ejected flits.
- ej_vld  out  NUM_EJECT  ejection valid; no backpressure.

Behaviour:
- Flit fields: age = [FLIT_W-1 -: AGE_W]; dst_x = [2*COORD_W-1:COORD_W]; dst_y = [COORD_W-1:0].
- Reset (reset=0): all pipeline registers cleared; dout_vld=0, dout_net=0, ej_vld=0, ej_flit=0, inj_rdy=0. Applies mid-traffic; in-flight flits are discarded.
- Stage 0 (input register, every cycle): capture din_net/din_vld. The age of each valid flit increments by 1, saturating at 2^AGE_W-1. Invalid slots are stored as all-zero.
- Stage 1 (combinational, from stage-0 registers):
  - Productive set per flit: W if dst_x<CUR_X, E if dst_x>CUR_X, S if dst_y<CUR_Y, N if dst_y>CUR_Y.
  - Preference order: the X direction before the Y direction.
  - Local flit: dst_x==CUR_X && dst_y==CUR_Y.
- Priority: higher age first; ties go to the lower port index.
- Ejection: local flits claim eject slots in priority order, up to NUM_EJECT. Eject slot k is filled in priority order, slot 0 first. Local flits that get no slot are deflected.
- Port allocation, sequential in priority order over non-ejected flits:
  - take the first free productive port in preference order;
  - otherwise take the lowest-index free port (deflection).
- Injection:
  - inj_rdy = reset && (number of non-ejected valid stage-0 flits < 4).
  - An accepted inj_flit has its age field forced to 0.
  - It is allocated after all network flits, using the same productive/deflection rule.
  - If inj_flit is local-destined, it is never ejected; it is routed out a network port.
- Stage 2 (output register): register allocated flits to dout_*, ejected flits to ej_*. Unused outputs have vld=0 and data=0.
- Latency: din to dout/ej = 2 cycles; inj to dout = 1 cycle.
- Invariant: every valid input or accepted injected flit appears on exactly one output, exactly once. No flit is dropped or duplicated.
- Simultaneous events:
  - all 4 inputs valid and non-local: inj_rdy=0;
  - inj_vld=0 with inj_rdy=1: no effect;
  - equal ages resolve by port index.

Optional Feature:
- BLESS_ROUTER_STATS_EN defined: adds outputs deflect_cnt (32) and eject_cnt (32).
  - Both are saturating counters, cleared by reset.
  - deflect_cnt increments by the number of flits assigned a non-productive port per cycle; an injected flit counts if deflected.
  - eject_cnt increments by the popcount of ej_vld at stage 2.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bless_pkg holds:
  - port index constants PORT_W=0, PORT_E=1, PORT_S=2, PORT_N=3, NUM_NET_PORTS=4;
  - field position functions/localparams for age, dst_x, dst_y;
  - the productive-vector width.
- One sub-module, bless_port_alloc: combinational priority ordering, ejection selection and sequential port allocation. Stage registers stay in the top.

Test Plan:
- Reset mid-traffic: 4 valid flits in flight, pull reset low → next sample dout_vld=0, ej_vld=0, inj_rdy=0. After release, inj_rdy=1 and no stale flits emerge.
- CUR=(2,2): W input dst=(4,2) age=5 → 2 cycles later dout_vld[E]=1, age=6, other dout_vld=0.
- Conflict: W dst=(4,2) age=3 and N dst=(4,2) age=9 → N flit on E with age 10; W flit deflected to W with age 4. deflect_cnt +1 if enabled.
- NUM_EJECT=1: E and S both dst=(2,2), ages 7 and 2 → E flit on ej_flit with age 8; S flit on W (lowest free) with age 3.
- Injection: 4 non-local valid inputs → inj_rdy=0. 3 inputs (N empty) with inj_vld=1, inj dst=(2,3) → inj_rdy=1; next cycle the injected flit is on N if free, with age 0.
- Age saturation: input age=255 (AGE_W=8) → output age=255; 254 → 255.
